// File: rtl/mult_error_sweep_controller_if.sv
// Command, product and statistics bundle between a sweep controller and its environment.
// cap_valid has no ready: the environment must take every one-cycle pulse, as stats are already updated when it rises.
interface mult_error_sweep_controller_if #(
    parameter int WIDTH = 8,
    parameter int ACC_W = 32
);
    logic                 start;
    logic                 abort;
    logic                 stall;
    logic [2*WIDTH-1:0]   exact_p;
    logic [2*WIDTH-1:0]   approx_p;
    logic [WIDTH-1:0]     op_a;
    logic [WIDTH-1:0]     op_b;
    logic                 cap_valid;
    logic                 busy;
    logic                 done;
    logic [2*WIDTH:0]     err_count;
    logic [ACC_W-1:0]     sum_ed;
    logic [2*WIDTH-1:0]   max_ed;
    logic [WIDTH-1:0]     max_a;
    logic [WIDTH-1:0]     max_b;

    modport master (
        output start, abort, stall, exact_p, approx_p,
        input  op_a, op_b, cap_valid, busy, done,
        input  err_count, sum_ed, max_ed, max_a, max_b
    );

    modport slave (
        input  start, abort, stall, exact_p, approx_p,
        output op_a, op_b, cap_valid, busy, done,
        output err_count, sum_ed, max_ed, max_a, max_b
    );
endinterface

// File: rtl/mult_error_sweep_controller.sv
// Sweeps every operand pair through an exact and an approximate multiplier and
// accumulates error count, summed error distance and worst-case error with its operands.
module mult_error_sweep_controller #(
    parameter int WIDTH = 8,
    parameter int ACC_W = 32
) (
    input  logic                         clk,
    input  logic                         rst_n,
    mult_error_sweep_controller_if.slave bus,
    output logic [1:0]                   dbg_state
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0]   OP_ONES = '1;
    localparam logic [WIDTH-1:0]   OP_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [2*WIDTH:0]   CNT_ONE = {{(2*WIDTH){1'b0}}, 1'b1};

    state_t               state;
    logic [WIDTH-1:0]     op_a;
    logic [WIDTH-1:0]     op_b;
    logic                 cap_valid;
    logic                 busy;
    logic                 done;
    logic [2*WIDTH:0]     err_count;
    logic [ACC_W-1:0]     sum_ed;
    logic [2*WIDTH-1:0]   max_ed;
    logic [WIDTH-1:0]     max_a;
    logic [WIDTH-1:0]     max_b;
    logic [2*WIDTH-1:0]   ed;

    // Subtracting the smaller from the larger keeps |difference| inside 2*WIDTH bits.
    always_comb begin
        ed = '0;
        if (bus.exact_p >= bus.approx_p) ed = bus.exact_p - bus.approx_p;
        else                             ed = bus.approx_p - bus.exact_p;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            op_a      <= '0;
            op_b      <= '0;
            cap_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err_count <= '0;
            sum_ed    <= '0;
            max_ed    <= '0;
            max_a     <= '0;
            max_b     <= '0;
        end else begin
            cap_valid <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        state     <= RUN;
                        op_a      <= '0;
                        op_b      <= '0;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        err_count <= '0;
                        sum_ed    <= '0;
                        max_ed    <= '0;
                        max_a     <= '0;
                        max_b     <= '0;
                    end
                end
                RUN: begin
                    if (bus.abort) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (!bus.stall) begin
                        if (ed != '0) err_count <= err_count + CNT_ONE;
                        sum_ed    <= sum_ed + ACC_W'(ed);
                        // Strictly greater keeps the first pair that reached the maximum.
                        if (ed > max_ed) begin
                            max_ed <= ed;
                            max_a  <= op_a;
                            max_b  <= op_b;
                        end
                        cap_valid <= 1'b1;
                        op_a      <= op_a + OP_ONE;
                        if (op_a == OP_ONES) begin
                            op_b <= op_b + OP_ONE;
                            if (op_b == OP_ONES) begin
                                state <= DONE;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.op_a      = op_a;
    assign bus.op_b      = op_b;
    assign bus.cap_valid = cap_valid;
    assign bus.busy      = busy;
    assign bus.done      = done;
    assign bus.err_count = err_count;
    assign bus.sum_ed    = sum_ed;
    assign bus.max_ed    = max_ed;
    assign bus.max_a     = max_a;
    assign bus.max_b     = max_b;
    assign dbg_state     = state;
endmodule

// File: tb/tb_mult_error_sweep_controller.sv
// Directed bench: WIDTH=8 exact loopback plus WIDTH=4 error, stall, abort, reset and priority scenarios.
module tb_mult_error_sweep_controller;
    logic clk;
    logic rst_n;
    logic [1:0] dbg8;
    logic [1:0] dbg4;
    int   mode4;
    int   n_checks;
    int   n_fail;

    mult_error_sweep_controller_if #(.WIDTH(8), .ACC_W(32)) ifc8 ();
    mult_error_sweep_controller_if #(.WIDTH(4), .ACC_W(32)) ifc4 ();

    mult_error_sweep_controller #(.WIDTH(8), .ACC_W(32)) dut8 (
        .clk(clk), .rst_n(rst_n), .bus(ifc8.slave), .dbg_state(dbg8));
    mult_error_sweep_controller #(.WIDTH(4), .ACC_W(32)) dut4 (
        .clk(clk), .rst_n(rst_n), .bus(ifc4.slave), .dbg_state(dbg4));

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- multiplier models ----------------
    assign ifc8.exact_p  = {8'd0, ifc8.op_a} * {8'd0, ifc8.op_b};
    assign ifc8.approx_p = ifc8.exact_p;
    assign ifc4.exact_p  = {4'd0, ifc4.op_a} * {4'd0, ifc4.op_b};
    always_comb begin
        ifc4.approx_p = ifc4.exact_p;
        case (mode4)
            1: ifc4.approx_p = ifc4.exact_p ^ 8'd1;
            2: if (ifc4.op_a == 4'd3 && ifc4.op_b == 4'd5) ifc4.approx_p = 8'd0;
            default: ifc4.approx_p = ifc4.exact_p;
        endcase
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic start4();
        ifc4.start = 1'b1;
        tick();
        ifc4.start = 1'b0;
    endtask

    task automatic run_until_done4(input int max_cycles, input bit toggle_stall,
                                   output int busy_cnt, output int cap_cnt, output bit timed_out);
        busy_cnt  = 0;
        cap_cnt   = 0;
        timed_out = 1'b1;
        for (int i = 0; i < max_cycles; i++) begin
            if (ifc4.busy) busy_cnt++;
            if (ifc4.cap_valid) cap_cnt++;
            if (ifc4.done) begin
                timed_out = 1'b0;
                break;
            end
            if (toggle_stall) ifc4.stall = ~ifc4.stall;
            tick();
        end
        ifc4.stall = 1'b0;
    endtask

    task automatic run_until_done8(input int max_cycles, output int busy_cnt, output bit timed_out);
        busy_cnt  = 0;
        timed_out = 1'b1;
        for (int i = 0; i < max_cycles; i++) begin
            if (ifc8.busy) busy_cnt++;
            if (ifc8.done) begin
                timed_out = 1'b0;
                break;
            end
            tick();
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        n_checks++;
        if ({ifc4.op_a, ifc4.op_b, ifc4.cap_valid, ifc4.busy, ifc4.done, ifc4.err_count,
             ifc4.sum_ed, ifc4.max_ed, ifc4.max_a, ifc4.max_b, dbg4} !== '0) begin
            n_fail++;
            $display("FAIL reset_w4: outputs not all zero, err_count=%0d state=%0d", ifc4.err_count, dbg4);
        end
        n_checks++;
        if ({ifc8.op_a, ifc8.op_b, ifc8.cap_valid, ifc8.busy, ifc8.done, ifc8.err_count,
             ifc8.sum_ed, ifc8.max_ed, ifc8.max_a, ifc8.max_b, dbg8} !== '0) begin
            n_fail++;
            $display("FAIL reset_w8: outputs not all zero, err_count=%0d state=%0d", ifc8.err_count, dbg8);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_exact_loopback();
        int busy_cnt;
        bit timed_out;
        ifc8.start = 1'b1;
        tick();
        ifc8.start = 1'b0;
        run_until_done8(70000, busy_cnt, timed_out);
        n_checks++;
        if (timed_out) begin n_fail++; $display("FAIL w8_timeout: done not seen within 70000 cycles"); end
        n_checks++;
        if (busy_cnt !== 65536) begin n_fail++; $display("FAIL w8_run_edges: got %0d expected 65536", busy_cnt); end
        n_checks++;
        if ({ifc8.err_count, ifc8.sum_ed, ifc8.max_ed, ifc8.max_a, ifc8.max_b} !== '0) begin
            n_fail++;
            $display("FAIL w8_stats: err=%0d sum=%0d max=%0d expected all 0", ifc8.err_count, ifc8.sum_ed, ifc8.max_ed);
        end
    endtask

    task automatic test_constant_error();
        int busy_cnt, cap_cnt;
        bit timed_out;
        mode4 = 1;
        start4();
        run_until_done4(1000, 1'b0, busy_cnt, cap_cnt, timed_out);
        n_checks++;
        if (timed_out) begin n_fail++; $display("FAIL const_timeout: done not seen"); end
        n_checks++;
        if (busy_cnt !== 256) begin n_fail++; $display("FAIL const_run_edges: got %0d expected 256", busy_cnt); end
        n_checks++;
        if (ifc4.err_count !== 9'd256) begin n_fail++; $display("FAIL const_err_count: got %0d expected 256", ifc4.err_count); end
        n_checks++;
        if (ifc4.sum_ed !== 32'd256) begin n_fail++; $display("FAIL const_sum_ed: got %0d expected 256", ifc4.sum_ed); end
        n_checks++;
        if (ifc4.max_ed !== 8'd1) begin n_fail++; $display("FAIL const_max_ed: got %0d expected 1", ifc4.max_ed); end
        n_checks++;
        if ({ifc4.max_a, ifc4.max_b} !== 8'h00) begin n_fail++; $display("FAIL const_max_ab: got %0d,%0d expected 0,0", ifc4.max_a, ifc4.max_b); end
        n_checks++;
        if ({ifc4.op_a, ifc4.op_b, ifc4.busy, dbg4} !== {4'd0, 4'd0, 1'b0, 2'd2}) begin
            n_fail++;
            $display("FAIL const_end_state: op_a=%0d op_b=%0d busy=%0d state=%0d expected 0 0 0 2", ifc4.op_a, ifc4.op_b, ifc4.busy, dbg4);
        end
    endtask

    task automatic test_single_fault();
        int busy_cnt, cap_cnt;
        bit timed_out;
        mode4 = 2;
        start4();
        n_checks++;
        if ({ifc4.done, ifc4.busy, ifc4.err_count} !== {1'b0, 1'b1, 9'd0}) begin
            n_fail++;
            $display("FAIL b2b_restart: done=%0d busy=%0d err=%0d expected 0 1 0", ifc4.done, ifc4.busy, ifc4.err_count);
        end
        run_until_done4(1000, 1'b0, busy_cnt, cap_cnt, timed_out);
        n_checks++;
        if (timed_out) begin n_fail++; $display("FAIL fault_timeout: done not seen"); end
        n_checks++;
        if (ifc4.err_count !== 9'd1) begin n_fail++; $display("FAIL fault_err_count: got %0d expected 1", ifc4.err_count); end
        n_checks++;
        if (ifc4.sum_ed !== 32'd15) begin n_fail++; $display("FAIL fault_sum_ed: got %0d expected 15", ifc4.sum_ed); end
        n_checks++;
        if (ifc4.max_ed !== 8'd15) begin n_fail++; $display("FAIL fault_max_ed: got %0d expected 15", ifc4.max_ed); end
        n_checks++;
        if ({ifc4.max_a, ifc4.max_b} !== {4'd3, 4'd5}) begin n_fail++; $display("FAIL fault_max_ab: got %0d,%0d expected 3,5", ifc4.max_a, ifc4.max_b); end
    endtask

    task automatic test_stall();
        int busy_cnt, cap_cnt;
        bit timed_out;
        mode4 = 1;
        ifc4.stall = 1'b0;
        start4();
        run_until_done4(2000, 1'b1, busy_cnt, cap_cnt, timed_out);
        n_checks++;
        if (timed_out) begin n_fail++; $display("FAIL stall_timeout: done not seen"); end
        n_checks++;
        if (busy_cnt !== 512) begin n_fail++; $display("FAIL stall_run_edges: got %0d expected 512", busy_cnt); end
        n_checks++;
        if (cap_cnt !== 256) begin n_fail++; $display("FAIL stall_cap_count: got %0d expected 256", cap_cnt); end
        n_checks++;
        if ({ifc4.err_count, ifc4.sum_ed, ifc4.max_ed, ifc4.max_a, ifc4.max_b} !== {9'd256, 32'd256, 8'd1, 4'd0, 4'd0}) begin
            n_fail++;
            $display("FAIL stall_stats: err=%0d sum=%0d max=%0d expected 256 256 1", ifc4.err_count, ifc4.sum_ed, ifc4.max_ed);
        end
    endtask

    task automatic test_abort_restart();
        int busy_cnt, cap_cnt;
        bit timed_out;
        mode4 = 1;
        start4();
        for (int i = 0; i < 10; i++) tick();
        ifc4.abort = 1'b1;
        tick();
        ifc4.abort = 1'b0;
        n_checks++;
        if ({dbg4, ifc4.done, ifc4.busy, ifc4.cap_valid} !== {2'd0, 1'b0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL abort_state: state=%0d done=%0d busy=%0d cap=%0d expected 0 0 0 0", dbg4, ifc4.done, ifc4.busy, ifc4.cap_valid);
        end
        n_checks++;
        if ({ifc4.err_count, ifc4.op_a, ifc4.op_b} !== {9'd10, 4'd10, 4'd0}) begin
            n_fail++;
            $display("FAIL abort_stats: err=%0d op_a=%0d op_b=%0d expected 10 10 0", ifc4.err_count, ifc4.op_a, ifc4.op_b);
        end
        tick(); tick();
        n_checks++;
        if ({ifc4.err_count, ifc4.sum_ed, ifc4.op_a} !== {9'd10, 32'd10, 4'd10}) begin
            n_fail++;
            $display("FAIL idle_stable: err=%0d sum=%0d op_a=%0d expected 10 10 10", ifc4.err_count, ifc4.sum_ed, ifc4.op_a);
        end
        start4();
        n_checks++;
        if ({ifc4.err_count, ifc4.sum_ed, ifc4.op_a} !== '0) begin
            n_fail++;
            $display("FAIL restart_clear: err=%0d sum=%0d op_a=%0d expected 0 0 0", ifc4.err_count, ifc4.sum_ed, ifc4.op_a);
        end
        run_until_done4(1000, 1'b0, busy_cnt, cap_cnt, timed_out);
        n_checks++;
        if (timed_out || ifc4.err_count !== 9'd256) begin
            n_fail++;
            $display("FAIL restart_err_count: got %0d expected 256 (timed_out=%0d)", ifc4.err_count, timed_out);
        end
        ifc4.abort = 1'b1;
        tick();
        ifc4.abort = 1'b0;
        n_checks++;
        if ({dbg4, ifc4.done, ifc4.err_count} !== {2'd2, 1'b1, 9'd256}) begin
            n_fail++;
            $display("FAIL abort_in_done: state=%0d done=%0d err=%0d expected 2 1 256", dbg4, ifc4.done, ifc4.err_count);
        end
    endtask

    task automatic test_reset_and_priority();
        mode4 = 1;
        start4();
        for (int i = 0; i < 19; i++) tick();
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({ifc4.op_a, ifc4.op_b, ifc4.cap_valid, ifc4.busy, ifc4.done, ifc4.err_count,
             ifc4.sum_ed, ifc4.max_ed, ifc4.max_a, ifc4.max_b, dbg4} !== '0) begin
            n_fail++;
            $display("FAIL mid_reset: op_a=%0d err=%0d busy=%0d state=%0d expected all 0", ifc4.op_a, ifc4.err_count, ifc4.busy, dbg4);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        ifc4.abort = 1'b1;
        start4();
        ifc4.abort = 1'b0;
        n_checks++;
        if ({dbg4, ifc4.busy} !== {2'd1, 1'b1}) begin
            n_fail++;
            $display("FAIL start_beats_abort: state=%0d busy=%0d expected 1 1", dbg4, ifc4.busy);
        end
        for (int i = 0; i < 5; i++) tick();
        start4();
        n_checks++;
        if ({ifc4.op_a, ifc4.err_count, ifc4.busy} !== {4'd6, 9'd6, 1'b1}) begin
            n_fail++;
            $display("FAIL start_in_run: op_a=%0d err=%0d busy=%0d expected 6 6 1", ifc4.op_a, ifc4.err_count, ifc4.busy);
        end
        ifc4.abort = 1'b1;
        ifc4.stall = 1'b1;
        tick();
        ifc4.abort = 1'b0;
        ifc4.stall = 1'b0;
        n_checks++;
        if ({dbg4, ifc4.op_a, ifc4.err_count} !== {2'd0, 4'd6, 9'd6}) begin
            n_fail++;
            $display("FAIL abort_beats_stall: state=%0d op_a=%0d err=%0d expected 0 6 6", dbg4, ifc4.op_a, ifc4.err_count);
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        n_checks   = 0;
        n_fail     = 0;
        mode4      = 0;
        ifc4.start = 1'b0;
        ifc4.abort = 1'b0;
        ifc4.stall = 1'b0;
        ifc8.start = 1'b0;
        ifc8.abort = 1'b0;
        ifc8.stall = 1'b0;
        test_reset();
        test_exact_loopback();
        test_constant_error();
        test_single_fault();
        test_stall();
        test_abort_restart();
        test_reset_and_priority();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
